// File: rtl/bk_pipelined_subtractor_pkg.sv
// Shared definitions for the Brent-Kung pipelined subtractor: legal widths,
// prefix-tree depth helper and the generate/propagate pair type.
package bk_pipelined_subtractor_pkg;

    localparam int NUM_LEGAL_WIDTHS = 5;
    localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{4, 8, 16, 32, 64};

    // Generate/propagate pair carried through every prefix-tree node.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix-tree levels for a power-of-two width.
    function automatic int bk_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when v is one of the supported operand widths.
    function automatic bit bk_width_legal(input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
            if (LEGAL_WIDTHS[i] == v) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// Brent-Kung prefix operator: merges a high group with the adjacent low group.
module bk_gp_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/bk_pipelined_subtractor.sv
// Three-stage pipelined subtractor (a - b - bin) using a Brent-Kung carry tree.
// S1: per-bit g/p of (a, ~b) and carry-in; S2: up-sweep groups; S3: down-sweep
// carries, difference and flags. Valid/ready handshake with bubble collapsing.
module bk_pipelined_subtractor
    import bk_pipelined_subtractor_pkg::*;
#(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int L = bk_log2(n);

    if (!bk_width_legal(n)) begin : g_illegal_width
        $error("bk_pipelined_subtractor: n must be 4, 8, 16, 32 or 64");
    end

    // Stage registers
    logic             s1_valid_q, s1_valid_d;
    logic [n-1:0]     s1_g_q, s1_g_d;
    logic [n-1:0]     s1_p_q, s1_p_d;
    logic             s1_cin_q, s1_cin_d;
    logic             s2_valid_q, s2_valid_d;
    gp_t  [n-1:0]     s2_grp_q, s2_grp_d;
    logic [n-1:0]     s2_p_q, s2_p_d;
    logic             s2_cin_q, s2_cin_d;
    logic             s3_valid_q, s3_valid_d;
    logic [n-1:0]     diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             load1, load2, load3;
    gp_t  [n-1:0]     up_root;
    gp_t  [n-1:0]     dn_root;
    logic [n:0]       carry;
    logic [n-1:0]     sum;
    logic [n-1:0]     root_p;
    logic             unused_root_p;

    genvar gi, gl, gk;

    // Up-sweep: level 0 folds the carry-in into bit 0, then log2(n) levels of
    // pairwise merges leave complete group terms at nodes (i+1) % 2^l == 0.
    for (gl = 0; gl <= L; gl++) begin : g_up
        gp_t [n-1:0] lvl;
        for (gi = 0; gi < n; gi++) begin : g_bit
            if (gl == 0) begin : g_leaf
                if (gi == 0) begin : g_cin
                    bk_gp_cell u_cell (
                        .g_hi (s1_g_q[0]),
                        .p_hi (s1_p_q[0]),
                        .g_lo (s1_cin_q),
                        .p_lo (1'b0),
                        .g    (lvl[0].g),
                        .p    (lvl[0].p)
                    );
                end else begin : g_pass
                    assign lvl[gi].g = s1_g_q[gi];
                    assign lvl[gi].p = s1_p_q[gi];
                end
            end else if (((gi + 1) % (1 << gl)) == 0) begin : g_node
                bk_gp_cell u_cell (
                    .g_hi (g_up[gl-1].lvl[gi].g),
                    .p_hi (g_up[gl-1].lvl[gi].p),
                    .g_lo (g_up[gl-1].lvl[gi - (1 << (gl - 1))].g),
                    .p_lo (g_up[gl-1].lvl[gi - (1 << (gl - 1))].p),
                    .g    (lvl[gi].g),
                    .p    (lvl[gi].p)
                );
            end else begin : g_pass
                assign lvl[gi] = g_up[gl-1].lvl[gi];
            end
        end
    end
    assign up_root = g_up[L].lvl;

    // Down-sweep: from the registered up-sweep result, fill the remaining
    // prefixes, level L-1 down to 1, so every node holds bits [i:0] + carry-in.
    for (gk = 0; gk < L; gk++) begin : g_dn
        localparam int LVL = L - gk;
        gp_t [n-1:0] lvl;
        for (gi = 0; gi < n; gi++) begin : g_bit
            if (gk == 0) begin : g_leaf
                assign lvl[gi] = s2_grp_q[gi];
            end else if ((((gi + 1) % (1 << LVL)) == (1 << (LVL - 1))) &&
                         (gi >= (1 << LVL))) begin : g_node
                bk_gp_cell u_cell (
                    .g_hi (g_dn[gk-1].lvl[gi].g),
                    .p_hi (g_dn[gk-1].lvl[gi].p),
                    .g_lo (g_dn[gk-1].lvl[gi - (1 << (LVL - 1))].g),
                    .p_lo (g_dn[gk-1].lvl[gi - (1 << (LVL - 1))].p),
                    .g    (lvl[gi].g),
                    .p    (lvl[gi].p)
                );
            end else begin : g_pass
                assign lvl[gi] = g_dn[gk-1].lvl[gi];
            end
        end
    end
    assign dn_root = g_dn[L-1].lvl;

    // Carry into bit i+1 is the prefix generate of bits [i:0]; bit 0 gets carry-in.
    assign carry[0] = s2_cin_q;
    for (gi = 0; gi < n; gi++) begin : g_carry
        assign carry[gi + 1] = dn_root[gi].g;
        assign root_p[gi]    = dn_root[gi].p;
    end
    assign unused_root_p = ^root_p;
    assign sum = s2_p_q ^ carry[n-1:0];

    // Handshake and next-state: a stage loads when empty or draining this cycle.
    always_comb begin
        load3 = !s3_valid_q || out_ready;
        load2 = !s2_valid_q || load3;
        load1 = !s1_valid_q || load2;

        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        s2_grp_d   = s2_grp_q;
        s2_p_d     = s2_p_q;
        s2_cin_d   = s2_cin_q;
        s3_valid_d = s3_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;

        if (load1) begin
            s1_valid_d = in_valid;
            s1_g_d     = a & ~b;
            s1_p_d     = a ^ ~b;
            s1_cin_d   = ~bin;
        end
        if (load2) begin
            s2_valid_d = s1_valid_q;
            s2_grp_d   = up_root;
            s2_p_d     = s1_p_q;
            s2_cin_d   = s1_cin_q;
        end
        if (load3) begin
            s3_valid_d = s2_valid_q;
            diff_d     = sum;
            bout_d     = ~carry[n];
            ovf_d      = carry[n] ^ carry[n-1];
            zero_d     = (sum == '0);
        end
    end

    // Pipeline state; reset empties every stage and clears the result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_grp_q   <= '0;
            s2_p_q     <= '0;
            s2_cin_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_grp_q   <= s2_grp_d;
            s2_p_q     <= s2_p_d;
            s2_cin_q   <= s2_cin_d;
            s3_valid_q <= s3_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = load1;
    assign out_valid = s3_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
